// File: rtl/prom_writer_pkg.sv
// Shared definitions for the PROM fuse writer: state encoding, response codes
// and default device timing.
package prom_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREREAD,
    ST_SETUP,
    ST_PULSE,
    ST_RECOVER,
    ST_VERIFY,
    ST_RESP
  } state_t;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_ILLEGAL = 2'd1;
  localparam logic [1:0] RSP_FAIL    = 2'd2;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_HEIGHT = 8;
  localparam int DEF_TSETUP = 2;
  localparam int DEF_TPW    = 10;
  localparam int DEF_TREC   = 2;
  localparam int DEF_MAXTRY = 4;

  localparam int TIMER_W = 8;

  // States in which the program data bus carries the target word.
  function automatic logic drivesData(input state_t s);
    return (s == ST_SETUP) || (s == ST_PULSE) || (s == ST_RECOVER);
  endfunction

endpackage

// File: rtl/prom_writer_timer.sv
// Loadable down-counter with a zero flag; times setup, pulse and recovery phases.
module prom_writer_timer
  import prom_writer_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/prom_writer.sv
// One-word-at-a-time fuse PROM programmer: pre-read legality check, then
// setup/pulse/recover/verify loops until the word reads back or tries run out.
module prom_writer
  import prom_writer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int TSETUP = DEF_TSETUP,
  parameter int TPW    = DEF_TPW,
  parameter int TREC   = DEF_TREC,
  parameter int MAXTRY = DEF_MAXTRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HEIGHT-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_err,
  output logic [2:0]        rsp_tries,
  output logic [HEIGHT-1:0] pa,
  output logic [WIDTH-1:0]  pd,
  output logic              pgm,
  output logic              cs_,
  input  logic [WIDTH-1:0]  q
);

  // The timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TIMER_W-1:0] LD_SETUP = TIMER_W'(TSETUP - 1);
  localparam logic [TIMER_W-1:0] LD_PULSE = TIMER_W'(TPW - 1);
  localparam logic [TIMER_W-1:0] LD_REC   = TIMER_W'(TREC - 1);
  localparam logic [2:0]         MAX_T    = 3'(MAXTRY);

  state_t              r_state;
  state_t              w_nextState;
  logic [HEIGHT-1:0]   r_addr;
  logic [WIDTH-1:0]    r_data;
  logic [2:0]          r_tries;
  logic [1:0]          r_rspErr;
  logic [2:0]          r_rspTries;
  logic [1:0]          w_rspErr;
  logic                w_timerLoad;
  logic [TIMER_W-1:0]  w_timerValue;
  logic                w_timerZero;

  prom_writer_timer #(.W(TIMER_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_timerLoad),
    .i_value (w_timerValue),
    .o_zero  (w_timerZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_timerLoad  = 1'b0;
    w_timerValue = '0;
    w_rspErr     = RSP_OK;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_nextState = ST_PREREAD;
      end
      ST_PREREAD: begin
        // A bit already blown where the target wants 0 can never be undone.
        if ((q & ~r_data) != '0) begin
          w_nextState = ST_RESP;
          w_rspErr    = RSP_ILLEGAL;
        end else if (q == r_data) begin
          w_nextState = ST_RESP;
        end else begin
          w_nextState  = ST_SETUP;
          w_timerLoad  = 1'b1;
          w_timerValue = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_timerZero) begin
          w_nextState  = ST_PULSE;
          w_timerLoad  = 1'b1;
          w_timerValue = LD_PULSE;
        end
      end
      ST_PULSE: begin
        if (w_timerZero) begin
          w_nextState  = ST_RECOVER;
          w_timerLoad  = 1'b1;
          w_timerValue = LD_REC;
        end
      end
      ST_RECOVER: begin
        if (w_timerZero) w_nextState = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (q == r_data) begin
          w_nextState = ST_RESP;
        end else if (r_tries == MAX_T) begin
          w_nextState = ST_RESP;
          w_rspErr    = RSP_FAIL;
        end else begin
          w_nextState  = ST_SETUP;
          w_timerLoad  = 1'b1;
          w_timerValue = LD_SETUP;
        end
      end
      ST_RESP: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    pgm       = 1'b0;
    cs_       = 1'b1;
    pa        = '0;
    pd        = '0;
    case (r_state)
      ST_IDLE:                 req_ready = 1'b1;
      ST_PREREAD, ST_VERIFY: begin
        cs_ = 1'b0;
        pa  = r_addr;
      end
      ST_SETUP, ST_RECOVER:    pa = r_addr;
      ST_PULSE: begin
        pgm = 1'b1;
        pa  = r_addr;
      end
      ST_RESP:                 rsp_valid = 1'b1;
      default: ;
    endcase
    if (drivesData(r_state)) pd = r_data;
  end

  // Tries count completed pulses only; an async reset mid-pulse discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_tries    <= '0;
      r_rspErr   <= RSP_OK;
      r_rspTries <= '0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_data  <= req_data;
        r_tries <= '0;
      end
      if (r_state == ST_PULSE && w_timerZero) r_tries <= r_tries + 3'd1;
      if (w_nextState == ST_RESP) begin
        r_rspErr   <= w_rspErr;
        r_rspTries <= r_tries;
      end
    end
  end

  assign rsp_err   = r_rspErr;
  assign rsp_tries = r_rspTries;

endmodule
